// File: rtl/verificador_porta_pkg.sv
// verificador_porta shared types and constants.
// Holds FSM encoding and gate-family truth tables.
package verificador_porta_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Bit i is the expected output for input index {a,b} == i.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic exp_bit(
    input logic [3:0] tt,
    input logic [1:0] idx
  );
    return tt[idx];
  endfunction

endpackage

// File: rtl/verificador_porta_if.sv
// Bundle between the gate exerciser and its controller/DUT.
// The slave side is the exerciser itself.
interface verificador_porta_if;
  import verificador_porta_pkg::*;

  logic                   start;
  logic                   y;
  logic                   a;
  logic                   b;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [2:0]             err_count;
  logic [NUM_VECTORS-1:0] fail_mask;

  modport slave (
    input  start, y,
    output a, b, busy, done, pass,
    output err_count, fail_mask
  );

  modport master (
    output start, y,
    input  a, b, busy, done, pass,
    input  err_count, fail_mask
  );

endinterface

// File: rtl/verificador_porta.sv
// Self-checking exerciser for a 2-input gate: walks 00..11,
// samples y after a settle interval and scores it.
module verificador_porta
  import verificador_porta_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE = TT_OR,
  parameter int         SETTLE      = 2
) (
  input logic               clk,
  input logic               rst,
  verificador_porta_if.slave bus
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [2:0] err, err_n;
  logic [3:0] mask, mask_n;
  logic       pass_q, pass_n;
  logic       miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      err    <= '0;
      mask   <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      err    <= err_n;
      mask   <= mask_n;
      pass_q <= pass_n;
    end
  end

  assign miss = bus.y != exp_bit(TRUTH_TABLE, idx);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    err_n   = err;
    mask_n  = mask;
    pass_n  = pass_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_APPLY;
          cnt_n   = '0;
          idx_n   = '0;
          err_n   = '0;
          mask_n  = '0;
          pass_n  = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST)
          state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (miss) begin
          mask_n[idx] = 1'b1;
          err_n       = err + 3'd1;
        end
        // pass is registered here so it is valid during DONE
        if (idx == 2'd3) begin
          state_n = S_DONE;
          pass_n  = (err_n == 3'd0);
        end else begin
          state_n = S_APPLY;
          idx_n   = idx + 2'd1;
          cnt_n   = '0;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  logic active;
  assign active = (state == S_APPLY) || (state == S_SAMPLE);

  assign bus.a         = active & idx[1];
  assign bus.b         = active & idx[0];
  assign bus.busy      = active;
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err;
  assign bus.fail_mask = mask;

endmodule

// File: tb/tb_verificador_porta.sv
// Directed bench for verificador_porta: OR and XOR loopbacks,
// faulty gates, ignored starts and asynchronous reset.
module tb_verificador_porta;
  import verificador_porta_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  verificador_porta_if bus0 ();
  verificador_porta_if bus1 ();

  verificador_porta u_or (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  verificador_porta #(
    .TRUTH_TABLE(TT_XOR),
    .SETTLE     (1)
  ) u_xor (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // mode 0: OR gate, 1: stuck-at-0, 2: AND gate
  assign bus0.y = (mode == 0) ? (bus0.a | bus0.b) :
                  (mode == 1) ? 1'b0 :
                                (bus0.a & bus0.b);
  assign bus1.y = bus1.a ^ bus1.b;

  assign bus0.start = start & ~sel;
  assign bus1.start = start & sel;

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [2:0] m_err;
  logic [3:0] m_mask;

  assign m_a    = sel ? bus1.a : bus0.a;
  assign m_b    = sel ? bus1.b : bus0.b;
  assign m_busy = sel ? bus1.busy : bus0.busy;
  assign m_done = sel ? bus1.done : bus0.done;
  assign m_pass = sel ? bus1.pass : bus0.pass;
  assign m_err  = sel ? bus1.err_count : bus0.err_count;
  assign m_mask = sel ? bus1.fail_mask : bus0.fail_mask;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 32'(bus0.a), 0);
    chk({tag, "_b"}, 32'(bus0.b), 0);
    chk({tag, "_busy"}, 32'(bus0.busy), 0);
    chk({tag, "_done"}, 32'(bus0.done), 0);
    chk({tag, "_pass"}, 32'(bus0.pass), 0);
    chk({tag, "_err"}, 32'(bus0.err_count), 0);
    chk({tag, "_mask"}, 32'(bus0.fail_mask), 0);
  endtask

  task automatic run(
    input logic s,
    input int   settle,
    input logic ep,
    input int   ee,
    input int   em,
    input logic poke
  );
    int nb, nd, dat;
    logic gp;
    logic [2:0] ge;
    logic [3:0] gm;
    nb = 0; nd = 0; dat = 0;
    gp = 1'bx; ge = 'x; gm = 'x;
    sel = s;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 5) start = 1'b0;
      if (m_busy) begin
        chk("ab", 32'({m_a, m_b}), 32'(nb / (settle + 1)));
        nb++;
      end
      if (m_done) begin
        nd++;
        if (dat == 0) begin
          dat = n; gp = m_pass; ge = m_err; gm = m_mask;
        end
      end
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'(4 * (settle + 1)));
    chk("done_at", 32'(dat), 32'(4 * (settle + 1) + 1));
    chk("done_count", 32'(nd), 1);
    chk("pass", 32'(gp), 32'(ep));
    chk("err_count", 32'(ge), 32'(ee));
    chk("fail_mask", 32'(gm), 32'(em));
    chk("pass_hold", 32'(m_pass), 32'(ep));
    chk("mask_hold", 32'(m_mask), 32'(em));
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    chk("rst_xor_busy", 32'(bus1.busy), 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bus0.busy), 0);
    chk("idle_done", 32'(bus0.done), 0);

    mode = 0; run(1'b0, 2, 1'b1, 0, 4'b0000, 1'b0);
    mode = 1; run(1'b0, 2, 1'b0, 3, 4'b1110, 1'b0);
    mode = 2; run(1'b0, 2, 1'b0, 2, 4'b0110, 1'b0);
    run(1'b1, 1, 1'b1, 0, 4'b0000, 1'b1);

    // Reset during APPLY of vector 2, then a clean run.
    sel = 1'b0; mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_ab", 32'({bus0.a, bus0.b}), 2);
    chk("mid_busy", 32'(bus0.busy), 1);
    #1 rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    mode = 0; run(1'b0, 2, 1'b1, 0, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
